// File: rtl/l1_d_controller_nway_if.sv
// Core-side and L2-side signal bundle of the N-way L1 data-cache controller.
// The slave modport is the controller's view; master is the core/L2 side.
interface l1_d_controller_nway_if #(
  parameter int TAG_W   = 21,
  parameter int INDEX_W = 5,
  parameter int WAYS    = 2,
  parameter int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
);
  logic               read_C_L1;
  logic               write_C_L1;
  logic [TAG_W-1:0]   tag_C_L1;
  logic [INDEX_W-1:0] index_C_L1;
  logic               flush;
  logic               ready_L2_L1;
  logic               stall;
  logic               refill;
  logic               update;
  logic               read_L1_L2;
  logic               write_L1_L2;
  logic [INDEX_W-1:0] index_L1_L2;
  logic [TAG_W-1:0]   tag_L1_L2;
  logic [TAG_W-1:0]   write_tag_L1_L2;
  logic [WAY_W-1:0]   way;

  modport slave (
    input  read_C_L1, write_C_L1, tag_C_L1, index_C_L1, flush, ready_L2_L1,
    output stall, refill, update, read_L1_L2, write_L1_L2, index_L1_L2,
           tag_L1_L2, write_tag_L1_L2, way
  );

  modport master (
    output read_C_L1, write_C_L1, tag_C_L1, index_C_L1, flush, ready_L2_L1,
    input  stall, refill, update, read_L1_L2, write_L1_L2, index_L1_L2,
           tag_L1_L2, write_tag_L1_L2, way
  );
endinterface

// File: rtl/l1_d_controller_nway.sv
// WAYS-way set-associative write-back/write-allocate L1 D-cache tag/state
// controller with true-LRU replacement, dirty-victim write-back and flush.
module l1_d_controller_nway #(
  parameter int TAG_W   = 21,
  parameter int INDEX_W = 5,
  parameter int WAYS    = 2
) (
  input logic                  clk,
  input logic                  rst,
  l1_d_controller_nway_if.slave bus
);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int SETS  = 1 << INDEX_W;
  localparam int PTR_W = INDEX_W + WAY_W;

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t             r_state;
  logic [WAY_W-1:0]   r_way;
  logic [PTR_W-1:0]   r_flushPtr;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAYS-1:0]    r_dirty [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [WAY_W-1:0]   r_age   [SETS][WAYS];

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_req;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hitWay;
  logic [WAY_W-1:0]   w_victim;
  logic               w_victimDirty;
  logic [INDEX_W-1:0] w_flushSet;
  logic [WAY_W-1:0]   w_flushWay;
  logic               w_flushLineDirty;
  logic               w_flushLast;
  logic               w_flushing;

  assign w_idx            = bus.index_C_L1;
  assign w_tag            = bus.tag_C_L1;
  assign w_req            = bus.read_C_L1 | bus.write_C_L1;
  assign w_flushSet       = r_flushPtr[PTR_W-1:WAY_W];
  assign w_flushWay       = r_flushPtr[WAY_W-1:0];
  assign w_flushLineDirty = r_valid[w_flushSet][w_flushWay] & r_dirty[w_flushSet][w_flushWay];
  assign w_flushLast      = (r_flushPtr == {PTR_W{1'b1}});
  assign w_flushing       = (r_state == S_FLUSH_SCAN) || (r_state == S_FLUSH_WB);

  // Victim preference: lowest invalid way wins (scanned downward), else the LRU way.
  always_comb begin
    w_hit    = 1'b0;
    w_hitWay = '0;
    w_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit    = 1'b1;
        w_hitWay = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_age[w_idx][w] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) w_victim = WAY_W'(w);
    end
    w_victimDirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
  end

  assign bus.stall       = ((r_state != S_IDLE) | w_req | bus.flush) & ~((r_state == S_COMPARE) & w_hit);
  assign bus.update      = (r_state == S_COMPARE) & w_hit & bus.write_C_L1;
  assign bus.refill      = (r_state == S_ALLOCATE) & bus.ready_L2_L1;
  assign bus.read_L1_L2  = (r_state == S_ALLOCATE);
  assign bus.write_L1_L2 = (r_state == S_WRITE_BACK) | (r_state == S_FLUSH_WB);
  assign bus.index_L1_L2 = w_flushing ? w_flushSet : w_idx;
  assign bus.tag_L1_L2   = w_tag;

  always_comb begin
    bus.write_tag_L1_L2 = '0;
    bus.way             = '0;
    case (r_state)
      S_COMPARE:    bus.way = w_hit ? w_hitWay : w_victim;
      S_WRITE_BACK: begin
        bus.way             = r_way;
        bus.write_tag_L1_L2 = r_tag[w_idx][r_way];
      end
      S_ALLOCATE:   bus.way = r_way;
      S_FLUSH_SCAN: bus.way = w_flushWay;
      S_FLUSH_WB:   begin
        bus.way             = w_flushWay;
        bus.write_tag_L1_L2 = r_tag[w_flushSet][w_flushWay];
      end
      default: ;
    endcase
  end

  // Flush ends by invalidating the whole cache in one step; LRU ages survive it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_way      <= '0;
      r_flushPtr <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_tag[s][w] <= '0;
          r_age[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.flush)  r_state <= S_FLUSH_SCAN;
          else if (w_req) r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (w_hit) begin
            if (bus.write_C_L1) r_dirty[w_idx][w_hitWay] <= 1'b1;
            for (int w = 0; w < WAYS; w++) begin
              if (r_age[w_idx][w] < r_age[w_idx][w_hitWay])
                r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
            end
            r_age[w_idx][w_hitWay] <= '0;
            r_state <= S_IDLE;
          end else begin
            r_way   <= w_victim;
            r_state <= w_victimDirty ? S_WRITE_BACK : S_ALLOCATE;
          end
        end
        S_WRITE_BACK: begin
          if (bus.ready_L2_L1) begin
            r_dirty[w_idx][r_way] <= 1'b0;
            r_state <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (bus.ready_L2_L1) begin
            r_tag[w_idx][r_way]   <= w_tag;
            r_valid[w_idx][r_way] <= 1'b1;
            r_dirty[w_idx][r_way] <= 1'b0;
            r_state <= S_COMPARE;
          end
        end
        S_FLUSH_SCAN, S_FLUSH_WB: begin
          if ((r_state == S_FLUSH_SCAN) && w_flushLineDirty) begin
            r_state <= S_FLUSH_WB;
          end else if ((r_state == S_FLUSH_SCAN) || bus.ready_L2_L1) begin
            if (r_state == S_FLUSH_WB) r_dirty[w_flushSet][w_flushWay] <= 1'b0;
            if (w_flushLast) begin
              for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
              r_flushPtr <= '0;
              r_state    <= S_IDLE;
            end else begin
              r_flushPtr <= r_flushPtr + 1'b1;
              r_state    <= S_FLUSH_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_d_controller_nway.sv
// Directed self-checking bench for the 4-way L1 D-cache controller.
module tb_l1_d_controller_nway;
  localparam int TAG_W   = 21;
  localparam int INDEX_W = 5;
  localparam int WAYS    = 4;
  localparam int WAY_W   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_d_controller_nway_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) bus ();

  l1_d_controller_nway #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  int obsCycles, obsReadCycles, obsFirstRead, obsRefills, obsWbN;
  logic obsUpdate, obsTimeout;
  logic [WAY_W-1:0]   obsRefillWay, obsDoneWay;
  logic [INDEX_W-1:0] wbIdx [4];
  logic [WAY_W-1:0]   wbWay [4];
  logic [TAG_W-1:0]   wbTag [4];

  // Plays the core and L2 for one request and/or flush, recording what the controller did.
  task automatic run(input logic rd, input logic wr, input logic fl,
                     input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx,
                     input int allocWait, input int wbWait);
    int  aCnt;
    int  wCnt;
    bit  done;
    aCnt = 0; wCnt = 0; done = 0;
    obsCycles = 0; obsReadCycles = 0; obsFirstRead = -1; obsRefills = 0; obsWbN = 0;
    obsUpdate = 0; obsRefillWay = '0; obsDoneWay = '0;
    @(negedge clk);
    bus.read_C_L1 = rd; bus.write_C_L1 = wr; bus.flush = fl;
    bus.tag_C_L1 = tag; bus.index_C_L1 = idx; bus.ready_L2_L1 = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        bus.flush = 1'b0;
      end
      #1;
      bus.ready_L2_L1 = 1'b0;
      if (bus.read_L1_L2) begin
        aCnt++; obsReadCycles++;
        if (obsFirstRead < 0) obsFirstRead = cyc;
        bus.ready_L2_L1 = (aCnt >= allocWait);
      end else if (bus.write_L1_L2) begin
        wCnt++;
        bus.ready_L2_L1 = (wCnt >= wbWait);
      end
      #1;
      if (bus.refill) begin
        obsRefills++; obsRefillWay = bus.way; aCnt = 0;
      end
      if (bus.write_L1_L2 && bus.ready_L2_L1) begin
        if (obsWbN < 4) begin
          wbIdx[obsWbN] = bus.index_L1_L2;
          wbWay[obsWbN] = bus.way;
          wbTag[obsWbN] = bus.write_tag_L1_L2;
        end
        obsWbN++; wCnt = 0;
      end
      if (!bus.stall) begin
        done = 1; obsCycles = cyc + 1; obsDoneWay = bus.way; obsUpdate = bus.update;
      end
    end
    obsTimeout = !done;
    @(negedge clk);
    bus.read_C_L1 = 1'b0; bus.write_C_L1 = 1'b0; bus.flush = 1'b0; bus.ready_L2_L1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.read_C_L1 = 0; bus.write_C_L1 = 0; bus.flush = 0; bus.ready_L2_L1 = 0;
    bus.tag_C_L1 = '0; bus.index_C_L1 = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); else passes++;
    checks++; if (bus.refill !== 1'b0) $display("[TB] FAIL reset_refill: got %b expected 0", bus.refill); else passes++;
    checks++; if (bus.update !== 1'b0) $display("[TB] FAIL reset_update: got %b expected 0", bus.update); else passes++;
    checks++; if (bus.read_L1_L2 !== 1'b0) $display("[TB] FAIL reset_read: got %b expected 0", bus.read_L1_L2); else passes++;
    checks++; if (bus.write_L1_L2 !== 1'b0) $display("[TB] FAIL reset_write: got %b expected 0", bus.write_L1_L2); else passes++;
    checks++; if (bus.write_tag_L1_L2 !== '0) $display("[TB] FAIL reset_wtag: got %0h expected 0", bus.write_tag_L1_L2); else passes++;
    checks++; if (bus.way !== '0) $display("[TB] FAIL reset_way: got %0d expected 0", bus.way); else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cold_read();
    run(1, 0, 0, 21'h000AB, 5'd3, 3, 1);
    checks++; if (obsTimeout !== 1'b0) $display("[TB] FAIL cold_timeout: got %b expected 0", obsTimeout); else passes++;
    checks++; if (obsCycles !== 6) $display("[TB] FAIL cold_cycles: got %0d expected 6", obsCycles); else passes++;
    checks++; if (obsReadCycles !== 3) $display("[TB] FAIL cold_read_cycles: got %0d expected 3", obsReadCycles); else passes++;
    checks++; if (obsRefills !== 1) $display("[TB] FAIL cold_refills: got %0d expected 1", obsRefills); else passes++;
    checks++; if (obsRefillWay !== 2'd0) $display("[TB] FAIL cold_refill_way: got %0d expected 0", obsRefillWay); else passes++;
    checks++; if (obsDoneWay !== 2'd0) $display("[TB] FAIL cold_hit_way: got %0d expected 0", obsDoneWay); else passes++;
    checks++; if (obsWbN !== 0) $display("[TB] FAIL cold_wb: got %0d expected 0", obsWbN); else passes++;
  endtask

  task automatic test_lru_victim();
    for (int t = 1; t <= 4; t++) begin
      run(1, 0, 0, TAG_W'(t), 5'd5, 1, 1);
      checks++; if (obsRefillWay !== WAY_W'(t - 1) || obsTimeout) $display("[TB] FAIL fill_way_%0d: got %0d expected %0d", t, obsRefillWay, t - 1); else passes++;
    end
    run(1, 0, 0, 21'd1, 5'd5, 1, 1);
    checks++; if (obsCycles !== 2) $display("[TB] FAIL lru_hit_cycles: got %0d expected 2", obsCycles); else passes++;
    checks++; if (obsRefills !== 0) $display("[TB] FAIL lru_hit_refill: got %0d expected 0", obsRefills); else passes++;
    run(1, 0, 0, 21'd5, 5'd5, 1, 1);
    checks++; if (obsRefillWay !== 2'd1) $display("[TB] FAIL lru_victim_way: got %0d expected 1", obsRefillWay); else passes++;
    checks++; if (obsWbN !== 0) $display("[TB] FAIL lru_no_wb: got %0d expected 0", obsWbN); else passes++;
    checks++; if (obsDoneWay !== 2'd1) $display("[TB] FAIL lru_rehit_way: got %0d expected 1", obsDoneWay); else passes++;
  endtask

  task automatic test_write_back();
    run(1, 0, 0, 21'd1, 5'd7, 1, 1);
    run(0, 1, 0, 21'd2, 5'd7, 1, 1);
    checks++; if (obsRefillWay !== 2'd1) $display("[TB] FAIL wmiss_way: got %0d expected 1", obsRefillWay); else passes++;
    checks++; if (obsUpdate !== 1'b1) $display("[TB] FAIL wmiss_update: got %b expected 1", obsUpdate); else passes++;
    run(0, 1, 0, 21'd2, 5'd7, 1, 1);
    checks++; if (obsCycles !== 2) $display("[TB] FAIL whit_cycles: got %0d expected 2", obsCycles); else passes++;
    checks++; if (obsUpdate !== 1'b1 || obsDoneWay !== 2'd1) $display("[TB] FAIL whit_update_way: got %b/%0d expected 1/1", obsUpdate, obsDoneWay); else passes++;
    run(1, 0, 0, 21'd3, 5'd7, 1, 1);
    run(1, 0, 0, 21'd4, 5'd7, 1, 1);
    run(1, 0, 0, 21'd1, 5'd7, 1, 1);
    run(1, 0, 0, 21'd5, 5'd7, 1, 2);
    checks++; if (obsWbN !== 1) $display("[TB] FAIL evict_wb_count: got %0d expected 1", obsWbN); else passes++;
    checks++; if (wbTag[0] !== 21'd2) $display("[TB] FAIL evict_wb_tag: got %0h expected 2", wbTag[0]); else passes++;
    checks++; if (wbIdx[0] !== 5'd7 || wbWay[0] !== 2'd1) $display("[TB] FAIL evict_wb_loc: got %0d/%0d expected 7/1", wbIdx[0], wbWay[0]); else passes++;
    checks++; if (obsRefillWay !== 2'd1) $display("[TB] FAIL evict_refill_way: got %0d expected 1", obsRefillWay); else passes++;
    checks++; if (obsCycles !== 6) $display("[TB] FAIL evict_cycles: got %0d expected 6", obsCycles); else passes++;
  endtask

  task automatic test_flush();
    run(1, 0, 0, 21'h10, 5'd0, 1, 1);
    run(0, 1, 0, 21'h20, 5'd0, 1, 1);
    run(0, 1, 0, 21'h30, 5'd31, 1, 1);
    run(0, 0, 1, 21'h0, 5'd0, 1, 2);
    checks++; if (obsTimeout !== 1'b0) $display("[TB] FAIL flush_timeout: got %b expected 0", obsTimeout); else passes++;
    checks++; if (obsWbN !== 2) $display("[TB] FAIL flush_wb_count: got %0d expected 2", obsWbN); else passes++;
    checks++; if (wbIdx[0] !== 5'd0 || wbWay[0] !== 2'd1 || wbTag[0] !== 21'h20) $display("[TB] FAIL flush_wb0: got %0d/%0d/%0h expected 0/1/20", wbIdx[0], wbWay[0], wbTag[0]); else passes++;
    checks++; if (wbIdx[1] !== 5'd31 || wbWay[1] !== 2'd0 || wbTag[1] !== 21'h30) $display("[TB] FAIL flush_wb1: got %0d/%0d/%0h expected 31/0/30", wbIdx[1], wbWay[1], wbTag[1]); else passes++;
    checks++; if (obsCycles !== 134) $display("[TB] FAIL flush_cycles: got %0d expected 134", obsCycles); else passes++;
    run(1, 0, 0, 21'h20, 5'd0, 1, 1);
    checks++; if (obsRefills !== 1 || obsRefillWay !== 2'd0) $display("[TB] FAIL flush_remiss0: got %0d/%0d expected 1/0", obsRefills, obsRefillWay); else passes++;
    run(1, 0, 0, 21'h30, 5'd31, 1, 1);
    checks++; if (obsRefills !== 1 || obsWbN !== 0) $display("[TB] FAIL flush_remiss31: got %0d/%0d expected 1/0", obsRefills, obsWbN); else passes++;
  endtask

  task automatic test_flush_with_read();
    run(0, 1, 0, 21'h40, 5'd2, 1, 1);
    run(1, 0, 1, 21'h40, 5'd2, 1, 2);
    checks++; if (obsWbN !== 1 || wbIdx[0] !== 5'd2 || wbTag[0] !== 21'h40) $display("[TB] FAIL fr_wb: got %0d/%0d/%0h expected 1/2/40", obsWbN, wbIdx[0], wbTag[0]); else passes++;
    checks++; if (obsFirstRead !== 133) $display("[TB] FAIL fr_first_read: got %0d expected 133", obsFirstRead); else passes++;
    checks++; if (obsCycles !== 135) $display("[TB] FAIL fr_cycles: got %0d expected 135", obsCycles); else passes++;
    checks++; if (obsRefills !== 1 || obsRefillWay !== 2'd0) $display("[TB] FAIL fr_refill: got %0d/%0d expected 1/0", obsRefills, obsRefillWay); else passes++;
  endtask

  task automatic test_reset_abort();
    bit seen;
    seen = 0;
    @(negedge clk);
    bus.read_C_L1 = 1'b1; bus.tag_C_L1 = 21'h55; bus.index_C_L1 = 5'd9; bus.ready_L2_L1 = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (bus.read_L1_L2) seen = 1;
    end
    checks++; if (seen !== 1'b1) $display("[TB] FAIL abort_alloc_seen: got %b expected 1", seen); else passes++;
    rst = 1'b1; bus.read_C_L1 = 1'b0;
    #1;
    checks++; if (bus.read_L1_L2 !== 1'b0) $display("[TB] FAIL abort_read: got %b expected 0", bus.read_L1_L2); else passes++;
    checks++; if (bus.stall !== 1'b0) $display("[TB] FAIL abort_stall: got %b expected 0", bus.stall); else passes++;
    @(negedge clk);
    rst = 1'b0;
    run(1, 0, 0, 21'h55, 5'd9, 2, 1);
    checks++; if (obsCycles !== 5 || obsReadCycles !== 2) $display("[TB] FAIL abort_retry_timing: got %0d/%0d expected 5/2", obsCycles, obsReadCycles); else passes++;
    checks++; if (obsRefills !== 1 || obsRefillWay !== 2'd0) $display("[TB] FAIL abort_retry_way: got %0d/%0d expected 1/0", obsRefills, obsRefillWay); else passes++;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_lru_victim();
    test_write_back();
    test_flush();
    test_flush_with_read();
    test_reset_abort();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
